// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: 8N1 frame constants and receiver state encoding shared with uart_tx
// Ports: none (package)
package uart_rx_pkg;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running prescaler emitting a one-clk tick every DIV clocks
// Ports: clk, rst (sync, active high), clr (restart phase), tick (one-clk pulse at wrap)
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int W = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt;
    assign tick = cnt == LAST;
    always_ff @(posedge clk)
        cnt <= (rst || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with oversampled mid-bit sampling
// Ports: clk, rst (sync, active high), rx (async serial line, idles high),
//        data (last good byte, LSB first on the wire), valid / frame_err (one-clk strobes),
//        busy (receiver not idle)
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int BAUD       = 9600,
    parameter int F          = 50000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int TICK_DIV = F / (BAUD * OVERSAMPLE);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
    localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

    rx_state_t state, state_n;
    logic rx_meta, rx_s, tick, clr, valid_n, ferr_n;
    logic [SW-1:0] scnt, scnt_n;
    logic [2:0] bcnt, bcnt_n;
    logic [DATA_BITS-1:0] shreg, shreg_n, data_n;

    // Clearing the prescaler on the start edge puts every later sample
    // at a fixed offset from the falling edge of the start bit.
    uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick)
    );

    assign busy = state != RX_IDLE;

    always_comb begin
        state_n = state;
        scnt_n  = tick ? scnt + 1'b1 : scnt;
        bcnt_n  = bcnt;
        shreg_n = shreg;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        clr     = 1'b0;
        case (state)
            RX_IDLE: if (rx_s == START_BIT) begin
                state_n = RX_START;
                scnt_n  = '0;
                clr     = 1'b1;
            end
            // Half a bit after the edge: a line back high means a glitch, not a start bit.
            RX_START: if (tick && scnt == S_MID) begin
                state_n = rx_s == START_BIT ? RX_DATA : RX_IDLE;
                scnt_n  = '0;
                bcnt_n  = '0;
            end
            RX_DATA: if (tick && scnt == S_END) begin
                shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                scnt_n  = '0;
                bcnt_n  = bcnt + 1'b1;
                state_n = bcnt == B_LAST ? RX_STOP : RX_DATA;
            end
            // Leaving at mid stop bit keeps half a bit of margin for a back-to-back start edge.
            RX_STOP: if (tick && scnt == S_END) begin
                scnt_n  = '0;
                valid_n = rx_s == STOP_BIT;
                ferr_n  = rx_s != STOP_BIT;
                data_n  = rx_s == STOP_BIT ? shreg : data;
                state_n = rx_s == STOP_BIT ? RX_IDLE : RX_WAIT_IDLE;
            end
            // A held-low line (break) must not be mistaken for a new start bit.
            RX_WAIT_IDLE: if (rx_s == STOP_BIT) state_n = RX_IDLE;
            default: state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= RX_IDLE;
            scnt      <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            state     <= state_n;
            scnt      <= scnt_n;
            bcnt      <= bcnt_n;
            shreg     <= shreg_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with a strobe scoreboard
// Ports: none (top-level bench)
module tb_uart_rx;
    localparam int BT = 160;

    typedef struct packed {
        logic       ferr;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic [7:0] data;
    logic valid, frame_err, busy;

    exp_t q[$];
    logic [7:0] last_data = 8'h00;
    int asserts = 0;
    int fails = 0;
    int nvalid = 0;
    int nferr = 0;
    int busy_cyc = 0;

    uart_rx #(.BAUD(10000), .F(1600000), .OVERSAMPLE(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t e;
        if (busy) busy_cyc += 1;
        if (valid) nvalid += 1;
        if (frame_err) nferr += 1;
        if (valid && frame_err) begin
            asserts += 1;
            fails += 1;
            $display("FAIL excl: valid=1 frame_err=1, required never both high");
        end else if (valid || frame_err) begin
            asserts += 1;
            if (q.size() == 0) begin
                fails += 1;
                $display("FAIL unexpected_strobe: valid=%b frame_err=%b data=%h, required no strobe", valid, frame_err, data);
            end else begin
                e = q.pop_front();
                if ({frame_err, data} !== {e.ferr, e.d}) begin
                    fails += 1;
                    $display("FAIL strobe: frame_err=%b data=%h, required frame_err=%b data=%h", frame_err, data, e.ferr, e.d);
                end
            end
        end
    end

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: simulation still running after 100000 clk, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic stop, input int bt);
        rx = 1'b0;
        repeat (bt) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bt) @(negedge clk);
        end
        rx = stop;
        repeat (bt) @(negedge clk);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        q.push_back({1'b0, b});
        last_data = b;
    endtask

    task automatic clear_counts();
        nvalid = 0;
        nferr = 0;
        busy_cyc = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        asserts += 1;
        if (q.size() != 0) begin
            fails += 1;
            $display("FAIL drain: %0d strobes outstanding, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        asserts += 4;
        if (data !== 8'h00) begin fails += 1; $display("FAIL reset_data: got %h, required 00", data); end
        if (valid !== 1'b0) begin fails += 1; $display("FAIL reset_valid: got %b, required 0", valid); end
        if (frame_err !== 1'b0) begin fails += 1; $display("FAIL reset_ferr: got %b, required 0", frame_err); end
        if (busy !== 1'b0) begin fails += 1; $display("FAIL reset_busy: got %b, required 0", busy); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_single();
        clear_counts();
        expect_byte(8'hA5);
        send_byte(8'hA5, 1'b1, BT);
        repeat (40) @(negedge clk);
        wait_drain();
        asserts += 5;
        if (nvalid != 1) begin fails += 1; $display("FAIL single_valid: %0d pulses, required 1", nvalid); end
        if (nferr != 0) begin fails += 1; $display("FAIL single_ferr: %0d pulses, required 0", nferr); end
        if (busy_cyc < 1510 || busy_cyc > 1530) begin fails += 1; $display("FAIL single_busy_len: %0d clk, required 1510..1530", busy_cyc); end
        if (busy !== 1'b0) begin fails += 1; $display("FAIL single_busy_end: got %b, required 0", busy); end
        if (data !== 8'hA5) begin fails += 1; $display("FAIL single_data_hold: got %h, required a5", data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3] = '{8'h00, 8'hFF, 8'h3C};
        clear_counts();
        for (int i = 0; i < 3; i++) begin
            expect_byte(bytes[i]);
            send_byte(bytes[i], 1'b1, BT);
        end
        repeat (40) @(negedge clk);
        wait_drain();
        asserts += 2;
        if (nvalid != 3) begin fails += 1; $display("FAIL b2b_valid: %0d pulses, required 3", nvalid); end
        if (nferr != 0) begin fails += 1; $display("FAIL b2b_ferr: %0d pulses, required 0", nferr); end
    endtask

    task automatic test_frame_err();
        clear_counts();
        q.push_back({1'b1, last_data});
        send_byte(8'h55, 1'b0, BT);
        repeat (20 * BT) @(negedge clk);
        asserts += 4;
        if (nferr != 1) begin fails += 1; $display("FAIL ferr_count: %0d pulses, required 1", nferr); end
        if (nvalid != 0) begin fails += 1; $display("FAIL ferr_valid: %0d pulses, required 0", nvalid); end
        if (busy !== 1'b1) begin fails += 1; $display("FAIL ferr_busy_break: got %b, required 1", busy); end
        if (data !== last_data) begin fails += 1; $display("FAIL ferr_data: got %h, required %h", data, last_data); end
        rx = 1'b1;
        repeat (5) @(negedge clk);
        asserts += 1;
        if (busy !== 1'b0) begin fails += 1; $display("FAIL ferr_busy_release: got %b, required 0", busy); end
        repeat (BT) @(negedge clk);
        wait_drain();
        clear_counts();
        expect_byte(8'h81);
        send_byte(8'h81, 1'b1, BT);
        wait_drain();
        asserts += 1;
        if (nvalid != 1) begin fails += 1; $display("FAIL ferr_recover: %0d pulses, required 1", nvalid); end
    endtask

    task automatic test_glitch();
        clear_counts();
        rx = 1'b0;
        repeat (40) @(negedge clk);
        rx = 1'b1;
        repeat (46) @(negedge clk);
        asserts += 3;
        if (busy !== 1'b0) begin fails += 1; $display("FAIL glitch_busy: got %b, required 0", busy); end
        if (nvalid != 0) begin fails += 1; $display("FAIL glitch_valid: %0d pulses, required 0", nvalid); end
        if (nferr != 0) begin fails += 1; $display("FAIL glitch_ferr: %0d pulses, required 0", nferr); end
        repeat (BT) @(negedge clk);
        clear_counts();
        expect_byte(8'h7E);
        send_byte(8'h7E, 1'b1, BT);
        wait_drain();
        asserts += 1;
        if (nvalid != 1) begin fails += 1; $display("FAIL glitch_recover: %0d pulses, required 1", nvalid); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b = 8'hC3;
        clear_counts();
        rx = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (BT) @(negedge clk);
        end
        rx = b[4];
        repeat (BT / 2) @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        @(negedge clk);
        asserts += 4;
        if (data !== 8'h00) begin fails += 1; $display("FAIL midrst_data: got %h, required 00", data); end
        if (valid !== 1'b0) begin fails += 1; $display("FAIL midrst_valid: got %b, required 0", valid); end
        if (frame_err !== 1'b0) begin fails += 1; $display("FAIL midrst_ferr: got %b, required 0", frame_err); end
        if (busy !== 1'b0) begin fails += 1; $display("FAIL midrst_busy: got %b, required 0", busy); end
        rst = 1'b0;
        last_data = 8'h00;
        repeat (2 * BT) @(negedge clk);
        asserts += 2;
        if (nvalid != 0) begin fails += 1; $display("FAIL midrst_nostrobe_valid: %0d pulses, required 0", nvalid); end
        if (nferr != 0) begin fails += 1; $display("FAIL midrst_nostrobe_ferr: %0d pulses, required 0", nferr); end
        expect_byte(8'h19);
        send_byte(8'h19, 1'b1, BT);
        wait_drain();
        asserts += 1;
        if (data !== 8'h19) begin fails += 1; $display("FAIL midrst_next: got %h, required 19", data); end
    endtask

    task automatic test_distort();
        int bts [2] = '{155, 165};
        for (int k = 0; k < 2; k++) begin
            clear_counts();
            expect_byte(8'h96);
            send_byte(8'h96, 1'b1, bts[k]);
            repeat (40) @(negedge clk);
            wait_drain();
            asserts += 1;
            if (nvalid != 1) begin fails += 1; $display("FAIL distort_%0d: %0d pulses, required 1", bts[k], nvalid); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_distort();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
